// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and hazard/forward response bundle for fwd_hazard_unit.
// Keep N, STAGES and NUM_SRC equal to the values given to the unit.
interface fwd_hazard_unit_if #(
    parameter int unsigned N       = 32,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned NUM_SRC = 2
);
    localparam int unsigned RW = $clog2(N);
    localparam int unsigned SW = $clog2(STAGES + 1);

    logic                   id_valid;
    logic [NUM_SRC*RW-1:0]  id_src;
    logic [NUM_SRC-1:0]     id_src_used;
    logic [RW-1:0]          id_dst;
    logic                   id_reg_write;
    logic                   id_is_load;
    logic                   id_is_muldiv;
    logic                   id_reads_hilo;
    logic                   flush;
    logic                   stall;
    logic [NUM_SRC*SW-1:0]  fwd_sel;
    logic                   md_busy;
    logic [15:0]            stall_cnt;

    modport master (
        output id_valid, id_src, id_src_used, id_dst, id_reg_write,
               id_is_load, id_is_muldiv, id_reads_hilo, flush,
        input  stall, fwd_sel, md_busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_dst, id_reg_write,
               id_is_load, id_is_muldiv, id_reads_hilo, flush,
        output stall, fwd_sel, md_busy, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: shadows in-flight destinations from EX onward and
// derives operand forward selects, load-use stall and mult/div busy stall.
module fwd_hazard_unit #(
    parameter int unsigned N          = 32,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned LOAD_STAGE = 1,
    parameter int unsigned MD_LAT     = 4
) (
    input  logic             clk,
    input  logic             rst,
    fwd_hazard_unit_if.slave bus
);
    localparam int unsigned RW = $clog2(N);
    localparam int unsigned SW = $clog2(STAGES + 1);
    localparam int unsigned CW = $clog2(MD_LAT + 1);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] dst;
        logic          reg_write;
        logic          is_load;
    } stage_t;

    stage_t                pipe [0:STAGES];
    logic [NUM_SRC*RW-1:0] ex_src;
    logic [NUM_SRC-1:0]    ex_src_used;
    logic [CW-1:0]         md_cnt;
    logic [15:0]           stall_count;

    logic [NUM_SRC*SW-1:0] fwd;
    logic [NUM_SRC-1:0]    lu_hit;
    logic                  load_use;
    logic                  md_hazard;
    logic                  stall_int;
    logic                  advance;

    // Forward select: descending scan so the youngest matching stage wins.
    always_comb begin
        fwd = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (pipe[0].valid && ex_src_used[i] && (ex_src[i*RW +: RW] != '0)) begin
                for (int k = int'(STAGES); k >= 1; k--) begin
                    if (pipe[k].valid && pipe[k].reg_write &&
                        (pipe[k].dst == ex_src[i*RW +: RW])) begin
                        fwd[i*SW +: SW] = SW'(k);
                    end
                end
            end
        end
    end

    // Load-use: only the nearest writer below LOAD_STAGE decides, so a younger
    // non-load writer hides an older load of the same register.
    always_comb begin
        lu_hit = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (bus.id_src_used[i] && (bus.id_src[i*RW +: RW] != '0)) begin
                for (int j = int'(LOAD_STAGE) - 1; j >= 0; j--) begin
                    if (pipe[j].valid && pipe[j].reg_write &&
                        (pipe[j].dst == bus.id_src[i*RW +: RW])) begin
                        lu_hit[i] = pipe[j].is_load;
                    end
                end
            end
        end
    end

    assign load_use  = bus.id_valid & (|lu_hit);
    assign md_hazard = bus.id_valid & (bus.id_is_muldiv | bus.id_reads_hilo) & (md_cnt != '0);
    assign stall_int = ~bus.flush & (load_use | md_hazard);
    assign advance   = ~bus.flush & ~stall_int;

    assign bus.stall     = stall_int;
    assign bus.fwd_sel   = fwd;
    assign bus.md_busy   = (md_cnt != '0);
    assign bus.stall_cnt = stall_count;

    // Shadow pipeline, mult/div occupancy and stall statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= int'(STAGES); k++) begin
                pipe[k] <= '0;
            end
            ex_src      <= '0;
            ex_src_used <= '0;
            md_cnt      <= '0;
            stall_count <= '0;
        end else begin
            for (int k = int'(STAGES); k >= 1; k--) begin
                pipe[k] <= pipe[k-1];
            end
            if (advance) begin
                pipe[0] <= '{valid: bus.id_valid, dst: bus.id_dst,
                             reg_write: bus.id_reg_write, is_load: bus.id_is_load};
                ex_src      <= bus.id_src;
                ex_src_used <= bus.id_src_used;
            end else begin
                pipe[0]     <= '0;
                ex_src      <= '0;
                ex_src_used <= '0;
            end

            if (advance && bus.id_valid && bus.id_is_muldiv) begin
                md_cnt <= CW'(MD_LAT);
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - CW'(1);
            end

            if (stall_int && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: a history-queue model predicts each
// cycle's outputs, a negedge monitor compares them against the DUT.
module tb_fwd_hazard_unit;
    localparam int unsigned N          = 32;
    localparam int unsigned STAGES     = 2;
    localparam int unsigned NUM_SRC    = 2;
    localparam int unsigned LOAD_STAGE = 1;
    localparam int unsigned MD_LAT     = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.N(N), .STAGES(STAGES), .NUM_SRC(NUM_SRC)) bus ();

    fwd_hazard_unit #(
        .N(N), .STAGES(STAGES), .NUM_SRC(NUM_SRC),
        .LOAD_STAGE(LOAD_STAGE), .MD_LAT(MD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       rw;
        logic       ld;
        logic       md;
        logic       hilo;
        logic [4:0] src0;
        logic [4:0] src1;
        logic       u0;
        logic       u1;
    } ins_t;

    typedef struct packed {
        logic        stall;
        logic [3:0]  fwd;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    ins_t hist[$];      // hist[k] = instruction currently in stage k (0 = EX)
    exp_t sbq[$];
    int   md_rem;
    int   scnt;
    int   n_chk;
    int   n_pass;
    ins_t cur;
    logic cur_fl;
    bit   last_stall;
    ins_t bub;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic ins_t mk(bit v, int dst, bit rw, bit ld, bit md, bit hilo,
                                int s0, bit u0, int s1, bit u1);
        ins_t r;
        r.v = v; r.dst = 5'(dst); r.rw = rw; r.ld = ld; r.md = md; r.hilo = hilo;
        r.src0 = 5'(s0); r.u0 = u0; r.src1 = 5'(s1); r.u1 = u1;
        return r;
    endfunction

    function automatic int exp_fwd(logic [4:0] s, logic u);
        if (!hist[0].v || !u || s == 5'd0) return 0;
        for (int k = 1; k <= int'(STAGES); k++)
            if (hist[k].v && hist[k].rw && hist[k].dst == s) return k;
        return 0;
    endfunction

    // Nearest writer in stages below LOAD_STAGE decides whether a load blocks.
    function automatic bit load_hit(logic [4:0] s, logic u);
        if (!u || s == 5'd0) return 1'b0;
        for (int j = 0; j < int'(LOAD_STAGE); j++)
            if (hist[j].v && hist[j].rw && hist[j].dst == s) return hist[j].ld;
        return 1'b0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k <= int'(STAGES); k++) hist.push_back(bub);
        md_rem = 0;
        scnt   = 0;
    endtask

    task automatic drive(input ins_t i, input logic fl);
        cur = i; cur_fl = fl;
        bus.id_valid      = i.v;
        bus.id_src        = {5'b0, 5'b0} | {i.src1, i.src0};
        bus.id_src_used   = {i.u1, i.u0};
        bus.id_dst        = i.dst;
        bus.id_reg_write  = i.rw;
        bus.id_is_load    = i.ld;
        bus.id_is_muldiv  = i.md;
        bus.id_reads_hilo = i.hilo;
        bus.flush         = fl;
    endtask

    // Predict this cycle, hand it to the monitor, then advance the model past the edge.
    task automatic step();
        exp_t e;
        bit   lu;
        lu = cur.v && (load_hit(cur.src0, cur.u0) || load_hit(cur.src1, cur.u1));
        e.stall = !cur_fl && (lu || (cur.v && (cur.md || cur.hilo) && md_rem > 0));
        e.fwd   = {2'(exp_fwd(hist[0].src1, hist[0].u1)), 2'(exp_fwd(hist[0].src0, hist[0].u0))};
        e.busy  = (md_rem > 0);
        e.cnt   = (scnt > 65535) ? 16'hFFFF : 16'(scnt);
        sbq.push_back(e);
        last_stall = e.stall;
        @(posedge clk);
        hist.push_front((cur_fl || e.stall) ? bub : cur);
        void'(hist.pop_back());
        if (!cur_fl && !e.stall && cur.v && cur.md) md_rem = int'(MD_LAT);
        else if (md_rem > 0) md_rem--;
        if (e.stall) scnt++;
        #1;
    endtask

    task automatic issue(input ins_t i);
        drive(i, 1'b0);
        for (int t = 0; t < 16; t++) begin
            step();
            if (!last_stall) return;
        end
        n_chk++;
        $display("FAIL issue_timeout: instruction still held after 16 cycles");
    endtask

    task automatic nops(input int n);
        drive(bub, 1'b0);
        repeat (n) step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("mon_stall",     32'(bus.stall),     32'(e.stall));
                chk("mon_fwd_sel",   32'(bus.fwd_sel),   32'(e.fwd));
                chk("mon_md_busy",   32'(bus.md_busy),   32'(e.busy));
                chk("mon_stall_cnt", 32'(bus.stall_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin : stim
        int   n;
        ins_t r;
        logic fl;
        n_chk = 0; n_pass = 0; bub = '0;
        model_reset();

        // Reset with a load sitting in ID.
        rst = 1'b1;
        drive(mk(1, 9, 1, 1, 0, 0, 9, 1, 9, 1), 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_stall",     32'(bus.stall),     32'd0);
        chk("rst_fwd_sel",   32'(bus.fwd_sel),   32'd0);
        chk("rst_md_busy",   32'(bus.md_busy),   32'd0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        step();
        nops(3);

        // EX-to-EX forwarding: add r3 ; sub r5,r3,r4.
        issue(mk(1, 3, 1, 0, 0, 0, 1, 1, 2, 1));
        drive(mk(1, 5, 1, 0, 0, 0, 3, 1, 4, 1), 1'b0);
        #1 chk("exex_stall", 32'(bus.stall), 32'd0);
        step();
        drive(bub, 1'b0);
        #1 chk("exex_fwd", 32'(bus.fwd_sel), 32'h1);
        step();
        nops(3);

        // Nearest writer wins, then the same with r0.
        issue(mk(1, 3, 1, 0, 0, 0, 1, 1, 2, 1));
        issue(mk(1, 3, 1, 0, 0, 0, 5, 1, 6, 1));
        issue(mk(1, 7, 1, 0, 0, 0, 3, 1, 3, 1));
        drive(bub, 1'b0);
        #1 chk("nearest_fwd", 32'(bus.fwd_sel), 32'h5);
        nops(3);
        issue(mk(1, 0, 1, 0, 0, 0, 1, 1, 2, 1));
        issue(mk(1, 0, 1, 0, 0, 0, 5, 1, 6, 1));
        issue(mk(1, 7, 1, 0, 0, 0, 0, 1, 0, 1));
        drive(bub, 1'b0);
        #1 chk("r0_fwd", 32'(bus.fwd_sel), 32'h0);
        nops(3);

        // Load-use: lw r2 ; add r6,r2,r1.
        issue(mk(1, 2, 1, 1, 0, 0, 4, 1, 0, 0));
        drive(mk(1, 6, 1, 0, 0, 0, 2, 1, 1, 1), 1'b0);
        #1 chk("lu_stall", 32'(bus.stall), 32'd1);
        step();
        #1 chk("lu_release", 32'(bus.stall), 32'd0);
        chk("lu_bubble_fwd", 32'(bus.fwd_sel), 32'h0);
        step();
        drive(bub, 1'b0);
        #1 chk("lu_fwd", 32'(bus.fwd_sel), 32'h2);
        chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
        step();
        nops(3);
        issue(mk(1, 2, 1, 1, 0, 0, 4, 1, 0, 0));
        drive(mk(1, 6, 1, 0, 0, 0, 2, 0, 1, 1), 1'b0);
        #1 chk("lu_unused_stall", 32'(bus.stall), 32'd0);
        step();
        nops(3);

        // Mult/div: mult ; mflo.
        drive(mk(1, 0, 0, 0, 1, 0, 8, 1, 9, 1), 1'b0);
        #1 chk("md_idle", 32'(bus.md_busy), 32'd0);
        step();
        drive(mk(1, 10, 1, 0, 0, 1, 0, 0, 0, 0), 1'b0);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.stall) begin
                n++;
                step();
            end else break;
        end
        chk("md_stall_len", 32'(n), 32'd4);
        chk("md_busy_drop", 32'(bus.md_busy), 32'd0);
        step();
        nops(3);
        #1 chk("md_cnt", 32'(bus.stall_cnt), 32'd5);

        // Flush in the hazard cycle kills the dependent instruction.
        issue(mk(1, 2, 1, 1, 0, 0, 4, 1, 0, 0));
        drive(mk(1, 6, 1, 0, 0, 0, 2, 1, 1, 1), 1'b1);
        #1 chk("flush_stall", 32'(bus.stall), 32'd0);
        step();
        drive(bub, 1'b0);
        #1 chk("flush_bubble_fwd", 32'(bus.fwd_sel), 32'h0);
        chk("flush_cnt", 32'(bus.stall_cnt), 32'd5);
        step();
        nops(3);

        // Randomized traffic over a small register window.
        repeat (1500) begin
            r = mk(($urandom % 5) != 0, $urandom % 8, ($urandom % 4) != 0,
                   ($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 10) == 0,
                   $urandom % 8, ($urandom % 4) != 0, $urandom % 8, ($urandom % 4) != 0);
            fl = (($urandom % 10) == 0);
            if (fl) begin
                drive(r, 1'b1);
                step();
            end else begin
                issue(r);
            end
        end
        nops(6);

        // Back-to-back mults drive stall_cnt into saturation.
        drive(mk(1, 0, 0, 0, 1, 0, 8, 1, 9, 1), 1'b0);
        for (int t = 0; t < 90000 && scnt < 65545; t++) step();
        #1 chk("cnt_sat", 32'(bus.stall_cnt), 32'hFFFF);
        nops(6);

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            n_chk++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard unit for the 5-stage MIPS pipeline. It keeps its own shadow record of every in-flight destination from EX down to a configurable depth. From that record it produces per-operand forward selects for the instruction in EX, a load-use stall and a multiply/divide busy stall for the instruction in ID. It replaces the fixed two-stage, two-operand forwarding logic.

Parameters:
N, 32, architectural register count; register index width RW = $clog2(N).
STAGES, 2, number of forwardable stages after EX (1=MEM, 2=WB, ...); must be >= 1.
NUM_SRC, 2, source operands per instruction.
LOAD_STAGE, 1, stage at whose end load data becomes available; a load may be forwarded only from a stage greater than LOAD_STAGE; must be < STAGES.
MD_LAT, 4, multiply/divide occupancy in cycles, counted from entry into EX; must be >= 1.
SW, $clog2(STAGES+1), width of one forward select.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  valid instruction in ID
id_src  in  NUM_SRC*RW  source register indices; operand i occupies bits [i*RW +: RW]
id_src_used  in  NUM_SRC  per-operand "actually read" flags
id_dst  in  RW  destination register
id_reg_write  in  1  instruction writes id_dst
id_is_load  in  1  instruction is a load
id_is_muldiv  in  1  instruction starts a mult/div
id_reads_hilo  in  1  instruction reads HI/LO (mfhi/mflo)
flush  in  1  kill ID and EX contents (branch/jump redirect)
stall  out  1  hold PC and IF/ID; insert a bubble into EX (combinational)
fwd_sel  out  NUM_SRC*SW  per EX operand: 0 = register file, k = forward from stage k
md_busy  out  1  mult/div unit occupied
stall_cnt  out  16  saturating count of stall cycles

Behaviour:
- Shadow record:
  - Stage 0 (EX) and stages 1..STAGES each hold: valid, dst, reg_write, is_load.
  - Stage 0 additionally holds src and src_used.
- Each cycle, stage k+1 <= stage k for k = 0..STAGES-1; stage STAGES is discarded.
- Stage 0 next value:
  - flush=1: bubble (valid=0).
  - else stall=1: bubble.
  - else: the ID fields, with valid=id_valid.
- Reset: all valid bits 0, md counter 0, stall_cnt 0. Consequently stall=0, fwd_sel=0 and md_busy=0 in the cycle after reset. Reset has priority over all other inputs.
- fwd_sel[i], combinational, from stage-0 state:
  - Equals 0 if stage 0 is invalid, src_used[i]=0, or src[i]==0.
  - Otherwise equals the smallest k in 1..STAGES with stage k valid, reg_write=1 and dst==src[i].
  - Equals 0 if no stage matches.
  - Register 0 is never forwarded.
- Load-use hazard:
  - Raised when id_valid=1 and some operand i with id_src_used[i]=1 and id_src[i]!=0 matches stage j (valid, reg_write, is_load, dst==id_src[i]) for some j < LOAD_STAGE.
  - A match only counts when stage j is the nearest writer of that register among stages 0..j; an older load shadowed by a younger non-load does not stall.
- Mult/div busy:
  - Counter loaded with MD_LAT when a valid id_is_muldiv instruction advances into EX (stage-0 capture without stall or flush).
  - Otherwise the counter decrements by 1 per cycle while non-zero.
  - md_busy = (counter != 0).
  - MD hazard = id_valid & (id_is_muldiv | id_reads_hilo) & md_busy.
  - flush does not clear the counter.
- stall = ~flush & (load-use hazard | MD hazard). flush wins over any simultaneous hazard.
- stall_cnt increments by 1 on every cycle with stall=1 and holds at 16'hFFFF.
- Stall duration:
  - A load-use stall lasts until the load reaches stage LOAD_STAGE; with the default this is exactly 1 cycle.
  - An MD stall lasts until the counter reaches 0.

Test Plan:
- Reset: assert rst 2 cycles with id_valid=1 and a load in the ID fields -> stall=0, fwd_sel=0, md_busy=0, stall_cnt=0 in the cycle after reset deasserts.
- EX-to-EX forwarding: add r3 then sub r5,r3,r4 back-to-back -> while sub is in EX, fwd_sel[0]=1, fwd_sel[1]=0, no stall.
- Nearest wins: add r3; or r3; and r7,r3,r3 -> while "and" is in EX, fwd_sel[0]=fwd_sel[1]=1 (not 2). Repeat with destination r0 -> fwd_sel=0.
- Load-use: lw r2 followed by add r6,r2,r1 -> stall=1 for exactly 1 cycle, EX bubble, then fwd_sel[0]=2. The same pair with the add's src_used[0]=0 gives no stall. stall_cnt=1.
- Mult/div: mult, then mflo immediately -> stall=1 for MD_LAT=4 cycles, md_busy drops 4 cycles after mult enters EX, then mflo advances.
- Flush vs hazard: load-use pair with flush=1 in the hazard cycle -> stall=0, stage 0 becomes a bubble, stall_cnt unchanged. Separately force 65540 stall cycles -> stall_cnt=16'hFFFF.
